// File: rtl/angle_frame_receiver.sv
// UART (8N1) receiver that turns {SYNC, HI, LO, CHK} frames into a validated 16-bit angle
// with a one-cycle ready strobe; anything malformed or stale produces a frameError strobe instead.
module angle_frame_receiver #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd1736,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [15:0] MAX_VALUE    = 16'd359,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serialFromArduino,
  output logic [15:0] data,
  output logic        isDataReady,
  output logic        frameError
);

  localparam logic [15:0] HALF_M1 = (CLKS_PER_BIT >> 1) - 16'd1;
  localparam logic [15:0] FULL_M1 = CLKS_PER_BIT - 16'd1;
  localparam logic [31:0] TMO_M1  = TIMEOUT_CLKS - 32'd1;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {F_WAIT_SYNC, F_GET_HI, F_GET_LO, F_GET_CHK} frame_state_t;

  logic         sync1_reg, sync2_reg, prev_reg;
  logic         fall;
  bit_state_t   bit_state_reg, bit_state_next;
  logic [15:0]  clk_cnt_reg;
  logic [2:0]   bit_idx_reg;
  logic [7:0]   shift_reg;
  logic         bit_tick, byte_valid, stop_err;
  frame_state_t frame_state_reg, frame_state_next;
  logic [7:0]   hi_reg, lo_reg;
  logic [15:0]  data_reg;
  logic         ready_reg, err_reg;
  logic [31:0]  tmo_cnt_reg;
  logic         in_frame, timeout, chk_ok, accept, reject;
  logic [7:0]   rx_byte;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= serialFromArduino;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign fall     = prev_reg & ~sync2_reg;
  assign bit_tick = (bit_state_reg == B_START) ? (clk_cnt_reg == HALF_M1) : (clk_cnt_reg == FULL_M1);
  assign rx_byte  = shift_reg;

  always_ff @(posedge clk) begin
    if (rst) bit_state_reg <= B_IDLE;
    else     bit_state_reg <= bit_state_next;
  end

  always_comb begin
    bit_state_next = bit_state_reg;
    case (bit_state_reg)
      B_IDLE:  if (fall) bit_state_next = B_START;
      B_START: if (bit_tick) bit_state_next = sync2_reg ? B_IDLE : B_DATA;
      B_DATA:  if (bit_tick && bit_idx_reg == 3'd7) bit_state_next = B_STOP;
      B_STOP:  if (bit_tick) bit_state_next = B_IDLE;
      default: bit_state_next = B_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    if (bit_state_reg == B_STOP && bit_tick) begin
      byte_valid = sync2_reg;
      stop_err   = ~sync2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_reg <= 16'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else begin
      if (bit_state_reg == B_IDLE || bit_tick) clk_cnt_reg <= 16'd0;
      else                                     clk_cnt_reg <= clk_cnt_reg + 16'd1;
      if (bit_state_reg != B_DATA) bit_idx_reg <= 3'd0;
      else if (bit_tick)           bit_idx_reg <= bit_idx_reg + 3'd1;
      if (bit_state_reg == B_DATA && bit_tick) shift_reg <= {sync2_reg, shift_reg[7:1]};
    end
  end

  assign in_frame = (frame_state_reg != F_WAIT_SYNC);
  assign timeout  = in_frame && (tmo_cnt_reg == TMO_M1);

  always_ff @(posedge clk) begin
    if (rst) frame_state_reg <= F_WAIT_SYNC;
    else     frame_state_reg <= frame_state_next;
  end

  // A timeout outranks a byte finishing in the same cycle; that byte is simply lost.
  always_comb begin
    frame_state_next = frame_state_reg;
    if (timeout || stop_err) begin
      frame_state_next = F_WAIT_SYNC;
    end else if (byte_valid) begin
      case (frame_state_reg)
        F_WAIT_SYNC: if (rx_byte == SYNC_BYTE) frame_state_next = F_GET_HI;
        F_GET_HI:    frame_state_next = F_GET_LO;
        F_GET_LO:    frame_state_next = F_GET_CHK;
        F_GET_CHK:   frame_state_next = F_WAIT_SYNC;
        default:     frame_state_next = F_WAIT_SYNC;
      endcase
    end
  end

  always_comb begin
    chk_ok = (rx_byte == (SYNC_BYTE ^ hi_reg ^ lo_reg)) && ({hi_reg, lo_reg} <= MAX_VALUE);
    accept = 1'b0;
    reject = timeout || stop_err;
    if (frame_state_reg == F_GET_CHK && byte_valid && !timeout) begin
      accept = chk_ok;
      reject = !chk_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg      <= 8'd0;
      lo_reg      <= 8'd0;
      data_reg    <= 16'd0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      tmo_cnt_reg <= 32'd0;
    end else begin
      if (frame_state_reg == F_GET_HI && byte_valid && !timeout) hi_reg <= rx_byte;
      if (frame_state_reg == F_GET_LO && byte_valid && !timeout) lo_reg <= rx_byte;
      if (accept) data_reg <= {hi_reg, lo_reg};
      ready_reg <= accept;
      err_reg   <= reject;
      if (!in_frame || byte_valid || timeout) tmo_cnt_reg <= 32'd0;
      else                                    tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
    end
  end

  assign data        = data_reg;
  assign isDataReady = ready_reg;
  assign frameError  = err_reg;

endmodule

// File: tb/tb_angle_frame_receiver.sv
// Directed bench for angle_frame_receiver: serialises frames onto the UART line and checks
// data, strobe counts and exact strobe timing against hand-computed values.
module tb_angle_frame_receiver;

  localparam int BIT_CLKS = 16;
  // Strobe lands 156 negedges after the start bit of the last byte is driven.
  localparam int STROBE_OFS = 156;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] data;
  logic        isDataReady;
  logic        frameError;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
  int rdy_last = 0, err_last = 0;
  int last_start = 0;

  angle_frame_receiver #(
    .CLKS_PER_BIT(16'd16),
    .SYNC_BYTE(8'hA5),
    .MAX_VALUE(16'd359),
    .TIMEOUT_CLKS(32'd2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serialFromArduino(rx),
    .data(data),
    .isDataReady(isDataReady),
    .frameError(frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (isDataReady) begin rdy_cnt = rdy_cnt + 1; rdy_last = cyc; end
    if (frameError)  begin err_cnt = err_cnt + 1; err_last = cyc; end
    if (isDataReady && frameError) both_cnt = both_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] chk);
    send_byte(8'hA5, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(chk, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data); end
    checks++; if (isDataReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", isDataReady); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frameError); end
    $display("reset: data=%0d ready=%b err=%b", data, isDataReady, frameError);
  endtask

  task automatic test_valid_frame();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h00, 8'hB4, 8'h11);
    checks++; if (data !== 16'd180) begin errors++; $display("FAIL valid_data: got %0d expected 180", data); end
    checks++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL valid_ready_cycles: got %0d expected 1", rdy_cnt - r0); end
    checks++; if (rdy_last !== last_start + STROBE_OFS) begin errors++; $display("FAIL valid_latency: got %0d expected %0d", rdy_last - last_start, STROBE_OFS); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL valid_no_err: got %0d expected 0", err_cnt - e0); end
    $display("frame A5,00,B4,11: data=%0d ready_cycles=%0d", data, rdy_cnt - r0);
  endtask

  task automatic test_bad_checksum();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h00, 8'hB4, 8'h12);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL badchk_err: got %0d expected 1", err_cnt - e0); end
    checks++; if (err_last !== last_start + STROBE_OFS) begin errors++; $display("FAIL badchk_err_timing: got %0d expected %0d", err_last - last_start, STROBE_OFS); end
    checks++; if (rdy_cnt - r0 !== 0) begin errors++; $display("FAIL badchk_no_ready: got %0d expected 0", rdy_cnt - r0); end
    checks++; if (data !== 16'd180) begin errors++; $display("FAIL badchk_data_hold: got %0d expected 180", data); end
    $display("frame A5,00,B4,12: err_cycles=%0d data=%0d", err_cnt - e0, data);
  endtask

  task automatic test_range();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h01, 8'h68, 8'hCC);
    checks++; if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin errors++; $display("FAIL range_360_reject: got err=%0d rdy=%0d expected err=1 rdy=0", err_cnt - e0, rdy_cnt - r0); end
    $display("frame A5,01,68,CC: err_cycles=%0d data=%0d", err_cnt - e0, data);
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h01, 8'h67, 8'hC3);
    checks++; if (data !== 16'd359) begin errors++; $display("FAIL range_359_data: got %0d expected 359", data); end
    checks++; if (rdy_cnt - r0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL range_359_strobes: got rdy=%0d err=%0d expected rdy=1 err=0", rdy_cnt - r0, err_cnt - e0); end
    $display("frame A5,01,67,C3: data=%0d ready_cycles=%0d", data, rdy_cnt - r0);
  endtask

  task automatic test_junk();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7E, 1'b1);
    send_frame(8'h00, 8'h5A, 8'hFF);
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL junk_no_err: got %0d expected 0", err_cnt - e0); end
    checks++; if (data !== 16'd90) begin errors++; $display("FAIL junk_data: got %0d expected 90", data); end
    checks++; if (rdy_cnt - r0 !== 1) begin errors++; $display("FAIL junk_ready: got %0d expected 1", rdy_cnt - r0); end
    $display("junk 3C,7E + frame A5,00,5A,FF: data=%0d err_cycles=%0d", data, err_cnt - e0);
  endtask

  task automatic test_glitch_stop();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (rdy_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_no_strobe: got rdy=%0d err=%0d expected 0 0", rdy_cnt - r0, err_cnt - e0); end
    $display("glitch 4clk: rdy=%0d err=%0d", rdy_cnt - r0, err_cnt - e0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL stop_err_count: got %0d expected 1", err_cnt - e0); end
    checks++; if (err_last !== last_start + STROBE_OFS) begin errors++; $display("FAIL stop_err_timing: got %0d expected %0d", err_last - last_start, STROBE_OFS); end
    $display("low stop on HI: err_cycles=%0d data=%0d", err_cnt - e0, data);
  endtask

  task automatic test_timeout_reset();
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2100) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0); end
    checks++; if (err_last !== last_start + STROBE_OFS + 2000) begin errors++; $display("FAIL timeout_timing: got %0d expected %0d", err_last - last_start, STROBE_OFS + 2000); end
    $display("timeout after A5,00: err_cycles=%0d", err_cnt - e0);
    e0 = err_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hB4, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 0 || rdy_cnt - r0 !== 0) begin errors++; $display("FAIL timeout_wait_sync: got err=%0d rdy=%0d expected 0 0", err_cnt - e0, rdy_cnt - r0); end
    $display("bytes 00,B4 after timeout: err=%0d rdy=%0d", err_cnt - e0, rdy_cnt - r0);
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 0 || rdy_cnt - r0 !== 0) begin errors++; $display("FAIL midreset_no_strobe: got err=%0d rdy=%0d expected 0 0", err_cnt - e0, rdy_cnt - r0); end
    checks++; if (data !== 16'd0) begin errors++; $display("FAIL midreset_data: got %0d expected 0", data); end
    $display("reset mid-LO: data=%0d err=%0d rdy=%0d", data, err_cnt - e0, rdy_cnt - r0);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_range();
    test_junk();
    test_glitch_stop();
    test_timeout_reset();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
